// File: rtl/iq_unpack.sv
// Interleaved I/Q byte unpacker: assembles I_lo,I_hi,Q_lo,Q_hi into sign-extended,
// Q-format-scaled I and Q words written as a pair. Define IQ_COUNT_EN to add sample_count.
module iq_unpack #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int QUANT_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_out,
  output logic                  i_wr_en,
  input  logic                  i_full,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  q_wr_en,
  input  logic                  q_full
`ifdef IQ_COUNT_EN
  ,
  output logic [31:0]           sample_count
`endif
);

  localparam int COMP_WIDTH = 2 * BYTE_WIDTH;

  localparam logic [2:0] S_I_LO  = 3'd0;
  localparam logic [2:0] S_I_HI  = 3'd1;
  localparam logic [2:0] S_Q_LO  = 3'd2;
  localparam logic [2:0] S_Q_HI  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [BYTE_WIDTH-1:0] i_lo_q, i_lo_d;
  logic [BYTE_WIDTH-1:0] i_hi_q, i_hi_d;
  logic [BYTE_WIDTH-1:0] q_lo_q, q_lo_d;
  logic [BYTE_WIDTH-1:0] q_hi_q, q_hi_d;

  logic                  pop;
  logic                  write;
  logic [COMP_WIDTH-1:0] i_word;
  logic [COMP_WIDTH-1:0] q_word;
  logic [DATA_WIDTH-1:0] i_scaled;
  logic [DATA_WIDTH-1:0] q_scaled;

  // Handshakes are masked during reset so nothing moves in the reset cycle.
  assign pop   = (state_q != S_WRITE) && !in_empty && !reset;
  assign write = (state_q == S_WRITE) && !i_full && !q_full && !reset;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    i_lo_d  = i_lo_q;
    i_hi_d  = i_hi_q;
    q_lo_d  = q_lo_q;
    q_hi_d  = q_hi_q;
    case (state_q)
      S_I_LO: begin
        if (pop) begin
          i_lo_d  = in_dout;
          state_d = S_I_HI;
        end
      end
      S_I_HI: begin
        if (pop) begin
          i_hi_d  = in_dout;
          state_d = S_Q_LO;
        end
      end
      S_Q_LO: begin
        if (pop) begin
          q_lo_d  = in_dout;
          state_d = S_Q_HI;
        end
      end
      S_Q_HI: begin
        if (pop) begin
          q_hi_d  = in_dout;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (write) begin
          state_d = S_I_LO;
        end
      end
      default: state_d = S_I_LO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_I_LO;
      i_lo_q  <= '0;
      i_hi_q  <= '0;
      q_lo_q  <= '0;
      q_hi_q  <= '0;
    end else begin
      state_q <= state_d;
      i_lo_q  <= i_lo_d;
      i_hi_q  <= i_hi_d;
      q_lo_q  <= q_lo_d;
      q_hi_q  <= q_hi_d;
    end
  end

  // Casting the signed 16-bit word to DATA_WIDTH sign-extends; the shift then truncates.
  assign i_word   = {i_hi_q, i_lo_q};
  assign q_word   = {q_hi_q, q_lo_q};
  assign i_scaled = DATA_WIDTH'($signed(i_word)) << QUANT_BITS;
  assign q_scaled = DATA_WIDTH'($signed(q_word)) << QUANT_BITS;

  assign in_rd_en = pop;
  assign i_wr_en  = write;
  assign q_wr_en  = write;
  assign i_out    = write ? i_scaled : '0;
  assign q_out    = write ? q_scaled : '0;

`ifdef IQ_COUNT_EN
  logic [31:0] count_q, count_d;

  assign count_d = write ? count_q + 32'd1 : count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sample_count = count_q;
`endif

endmodule

// File: tb/tb_iq_unpack.sv
// Directed and streaming bench for iq_unpack; a behavioural input FIFO and write logger
// surround the DUT, and each scenario task checks its own results.
module tb_iq_unpack;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_dout = 8'h00;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [31:0] i_out;
  logic        i_wr_en;
  logic        i_full = 1'b0;
  logic [31:0] q_out;
  logic        q_wr_en;
  logic        q_full = 1'b0;
`ifdef IQ_COUNT_EN
  logic [31:0] sample_count;
`endif

  iq_unpack #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .QUANT_BITS(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .i_out    (i_out),
    .i_wr_en  (i_wr_en),
    .i_full   (i_full),
    .q_out    (q_out),
    .q_wr_en  (q_wr_en),
    .q_full   (q_full)
`ifdef IQ_COUNT_EN
    ,
    .sample_count (sample_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  byte_q[$];
  int          gap_mode = 0;
  int          gap_cnt = 0;
  int          bp_arm = 0;
  int          bp_cnt = 0;
  bit          bp_active = 0;
  bit          rand_full = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  int          viol = 0;
  int          pop4_cyc[$];
  logic [31:0] wr_i[$];
  logic [31:0] wr_q[$];
  int          wr_cyc[$];

  // Input FIFO model plus write logger: drive on the falling edge, observe 2 ns later.
  always @(negedge clock) begin
    cyc++;
    if (gap_cnt > 0) begin
      in_empty = 1'b1;
      in_dout  = 8'($urandom);
      gap_cnt--;
    end else if (byte_q.size() > 0) begin
      in_empty = 1'b0;
      in_dout  = byte_q[0];
    end else begin
      in_empty = 1'b1;
      in_dout  = 8'($urandom);
    end
    bp_active = 1'b0;
    if (bp_cnt > 0) begin
      q_full    = 1'b1;
      i_full    = 1'b0;
      bp_active = 1'b1;
      bp_cnt--;
    end else if (rand_full) begin
      i_full = ($urandom_range(0, 3) == 0);
      q_full = ($urandom_range(0, 3) == 0);
    end else begin
      i_full = 1'b0;
      q_full = 1'b0;
    end
    #2;
    if (in_rd_en && in_empty) viol++;
    if (i_wr_en !== q_wr_en) viol++;
    if (!i_wr_en && (i_out !== 32'h0 || q_out !== 32'h0)) viol++;
    if (reset && (in_rd_en || i_wr_en || q_wr_en)) viol++;
    if (bp_active && (in_rd_en || i_wr_en)) viol++;
    if (i_wr_en && q_wr_en) begin
      wr_i.push_back(i_out);
      wr_q.push_back(q_out);
      wr_cyc.push_back(cyc);
    end
    if (in_rd_en && !in_empty) begin
      byte_q.delete(0);
      pop_cnt++;
      if (gap_mode == 1) gap_cnt = 3;
      else if (gap_mode == 2) gap_cnt = $urandom_range(0, 2);
      if (pop_cnt % 4 == 0) begin
        pop4_cyc.push_back(cyc);
        if (bp_arm > 0) begin
          bp_cnt = bp_arm;
          bp_arm = 0;
        end
      end
    end
  end

  task automatic clear_log();
    wr_i.delete();
    wr_q.delete();
    wr_cyc.delete();
    pop4_cyc.delete();
    viol = 0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wr_i.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic push_sample(input logic [15:0] iv, input logic [15:0] qv);
    byte_q.push_back(iv[7:0]);
    byte_q.push_back(iv[15:8]);
    byte_q.push_back(qv[7:0]);
    byte_q.push_back(qv[15:8]);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    byte_q.delete();
    gap_cnt = 0;
    repeat (n) @(negedge clock);
    reset   = 1'b0;
    pop_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    byte_q.push_back(8'h5A);
    repeat (2) @(negedge clock);
    #3;
    checks++;
    if (in_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_en: got %b want 0", in_rd_en);
    end
    checks++;
    if (i_wr_en !== 1'b0 || q_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_en: got i=%b q=%b want 0/0", i_wr_en, q_wr_en);
    end
    checks++;
    if (i_out !== 32'h0 || q_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got i=%h q=%h want 0/0", i_out, q_out);
    end
`ifdef IQ_COUNT_EN
    checks++;
    if (sample_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_count: got %h want 0", sample_count);
    end
`endif
    byte_q.delete();
    @(negedge clock);
    reset   = 1'b0;
    pop_cnt = 0;
    clear_log();
  endtask

  task automatic test_basic();
    clear_log();
    gap_mode = 0;
    push_sample(16'h1234, 16'hABCD);
    wait_writes(1, 60);
    checks++;
    if (wr_i.size() != 1) begin
      errors++;
      $display("FAIL basic_count: got %0d writes want 1", wr_i.size());
    end else begin
      checks++;
      if (wr_i[0] !== 32'h0048D000 || wr_q[0] !== 32'hFEAF3400) begin
        errors++;
        $display("FAIL basic_value: got i=%h q=%h want 0048d000/feaf3400", wr_i[0], wr_q[0]);
      end
      checks++;
      if (pop4_cyc.size() < 1 || wr_cyc[0] != pop4_cyc[0] + 1) begin
        errors++;
        $display("FAIL basic_latency: write at cycle %0d, 4th pop list size %0d",
                 wr_cyc[0], pop4_cyc.size());
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL basic_protocol: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_starvation();
    clear_log();
    gap_mode = 1;
    push_sample(16'h1234, 16'hABCD);
    wait_writes(1, 120);
    gap_mode = 0;
    gap_cnt  = 0;
    checks++;
    if (wr_i.size() != 1) begin
      errors++;
      $display("FAIL starve_count: got %0d writes want 1", wr_i.size());
    end else begin
      checks++;
      if (wr_i[0] !== 32'h0048D000 || wr_q[0] !== 32'hFEAF3400) begin
        errors++;
        $display("FAIL starve_value: got i=%h q=%h want 0048d000/feaf3400", wr_i[0], wr_q[0]);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL starve_protocol: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    bp_arm = 6;
    push_sample(16'h1234, 16'hABCD);
    push_sample(16'h8000, 16'h7FFF);
    wait_writes(2, 120);
    checks++;
    if (wr_i.size() != 2 || pop4_cyc.size() != 2) begin
      errors++;
      $display("FAIL bp_count: got %0d writes / %0d samples want 2/2", wr_i.size(), pop4_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[0] != pop4_cyc[0] + 7) begin
        errors++;
        $display("FAIL bp_hold: write %0d cycles after 4th pop want 7", wr_cyc[0] - pop4_cyc[0]);
      end
      checks++;
      if (wr_i[0] !== 32'h0048D000 || wr_q[0] !== 32'hFEAF3400) begin
        errors++;
        $display("FAIL bp_value0: got i=%h q=%h want 0048d000/feaf3400", wr_i[0], wr_q[0]);
      end
      checks++;
      if (wr_i[1] !== 32'hFE000000 || wr_q[1] !== 32'h01FFFC00 || wr_cyc[1] != pop4_cyc[1] + 1) begin
        errors++;
        $display("FAIL bp_value1: got i=%h q=%h lat=%0d want fe000000/01fffc00 lat=1",
                 wr_i[1], wr_q[1], wr_cyc[1] - pop4_cyc[1]);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bp_protocol: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_log();
    byte_q.push_back(8'h11);
    byte_q.push_back(8'h22);
    while (pop_cnt % 4 != 2 && k < 50) begin
      @(negedge clock);
      k++;
    end
    pulse_reset(1);
    push_sample(16'h8000, 16'h7FFF);
    wait_writes(1, 60);
    checks++;
    if (wr_i.size() != 1) begin
      errors++;
      $display("FAIL rstmid_count: got %0d writes want 1", wr_i.size());
    end else begin
      checks++;
      if (wr_i[0] !== 32'hFE000000 || wr_q[0] !== 32'h01FFFC00) begin
        errors++;
        $display("FAIL rstmid_value: got i=%h q=%h want fe000000/01fffc00", wr_i[0], wr_q[0]);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL rstmid_protocol: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_i[$];
    logic [31:0] exp_q[$];
    logic [15:0] iv;
    logic [15:0] qv;
    int          bad = 0;
    pulse_reset(2);
    clear_log();
    for (int n = 0; n < 1000; n++) begin
      case (n)
        0:       begin iv = 16'h7FFF; qv = 16'h8000; end
        1:       begin iv = 16'h0000; qv = 16'hFFFF; end
        default: begin iv = 16'($urandom); qv = 16'($urandom); end
      endcase
      push_sample(iv, qv);
      exp_i.push_back({{16{iv[15]}}, iv} << 10);
      exp_q.push_back({{16{qv[15]}}, qv} << 10);
    end
    gap_mode  = 2;
    rand_full = 1;
    wait_writes(1000, 40000);
    gap_mode  = 0;
    rand_full = 0;
    repeat (4) @(negedge clock);
    checks++;
    if (wr_i.size() != 1000) begin
      errors++;
      $display("FAIL stream_count: got %0d writes want 1000", wr_i.size());
    end
    for (int n = 0; n < 1000 && n < wr_i.size(); n++) begin
      checks++;
      if (wr_i[n] !== exp_i[n] || wr_q[n] !== exp_q[n]) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL stream_sample[%0d]: got i=%h q=%h want %h/%h",
                   n, wr_i[n], wr_q[n], exp_i[n], exp_q[n]);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL stream_protocol: got %0d violations want 0", viol);
    end
`ifdef IQ_COUNT_EN
    checks++;
    if (sample_count !== 32'd1000) begin
      errors++;
      $display("FAIL stream_sample_count: got %0d want 1000", sample_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_streaming();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_unpack.md
# iq_unpack

Front-end byte unpacker that reads the raw interleaved I/Q byte stream from the input FIFO and writes fixed-point I and Q samples into the paired FIFOs consumed by the complex FIR stage. It is the writer side of the I/Q FIFO interface.
- Each sample is four little-endian bytes: I_lo, I_hi, Q_lo, Q_hi.
- Each 16-bit signed component is sign-extended and scaled into the pipeline's Q10 fixed-point format.
- I and Q are always written together.

## Interface
Parameters:
- DATA_WIDTH, 32, width of I/Q output words
- BYTE_WIDTH, 8, width of input FIFO word
- QUANT_BITS, 10, left shift applied to each sign-extended 16-bit component (fractional bits)

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_dout  input  BYTE_WIDTH  input FIFO data; first-word-fall-through, valid whenever in_empty=0
- in_empty  input  1  input FIFO empty
- in_rd_en  output  1  input FIFO pop
- i_out  output  DATA_WIDTH  I sample to I FIFO
- i_wr_en  output  1  I FIFO push
- i_full  input  1  I FIFO full
- q_out  output  DATA_WIDTH  Q sample to Q FIFO
- q_wr_en  output  1  Q FIFO push
- q_full  input  1  Q FIFO full
- sample_count  output  32  samples written (present only with IQ_COUNT_EN)

## Operation
- FSM states: I_LO, I_HI, Q_LO, Q_HI, WRITE. Reset state I_LO.
- Byte states (I_LO..Q_HI):
  - in_rd_en = !in_empty, driven combinationally.
  - On a pop, in_dout is latched into the matching byte register and the FSM advances: I_LO→I_HI→Q_LO→Q_HI→WRITE.
  - If in_empty=1, the FSM holds and nothing is latched.
- WRITE state:
  - The FSM writes only when i_full=0 AND q_full=0.
  - On a write, i_wr_en=q_wr_en=1 in the same cycle, and the FSM returns to I_LO.
  - If either FIFO is full, both wr_en stay 0 and the FSM holds in WRITE.
  - I is never written without Q, and Q is never written without I.
  - No byte is popped while in WRITE.
- Arithmetic:
  - i_out = sign_extend_DATA_WIDTH({I_hi,I_lo}) << QUANT_BITS; q_out likewise from {Q_hi,Q_lo}.
  - Result truncates to DATA_WIDTH. With the defaults, ±32767·1024 fits without overflow.
- i_out and q_out are driven 0 in any cycle where wr_en=0.
- Empty/full signals are sampled only in their own states. An empty input during WRITE or a full output during a byte state has no effect.

## Timing
- Reset values:
  - in_rd_en=0, i_wr_en=0, q_wr_en=0, i_out=0, q_out=0.
  - All byte registers 0, state I_LO, sample_count=0.
- Reset mid-sample: any partially assembled bytes are discarded. The next accepted byte is treated as I_lo. No write occurs in the reset cycle.
- Throughput: 5 cycles per sample at best (4 pop cycles + 1 write cycle).
- Latency: the write occurs the cycle after the Q_hi pop, with no backpressure.
- Stalls insert whole cycles with no side effects. Byte order is never reset by stalls; only reset realigns it.

## Configuration
- IQ_COUNT_EN defined:
  - Adds the 32-bit sample_count output register.
  - It increments by 1 in each cycle with i_wr_en=1 and wraps 0xFFFFFFFF→0.
  - It is cleared by reset.
- IQ_COUNT_EN undefined: the sample_count port and its register are absent, and the rest of the behaviour is identical.

## Test plan
- Basic sample:
  - Stimulus: bytes 0x34,0x12,0xCD,0xAB, FIFOs never full.
  - Required response: exactly one write with i_out=0x0048D000 and q_out=0xFEAF3400, on the cycle after the 4th pop.
- Input starvation:
  - Stimulus: same bytes with in_empty=1 for 3 cycles between every byte.
  - Required response: identical output values, one write, and in_rd_en never asserted while empty.
- Output backpressure:
  - Stimulus: q_full=1 for 6 cycles on WRITE entry (i_full=0).
  - Required response: no wr_en for 6 cycles, then a single simultaneous I/Q write, and no in_rd_en during the hold.
- Reset mid-sample:
  - Stimulus: pop 0x11,0x22, pulse reset, then feed 0x00,0x80,0xFF,0x7F.
  - Required response: i_out=0xFE000000 and q_out=0x01FFFC00, with no write from the partial sample.
- Streaming:
  - Stimulus: 1000 random samples with random empty/full gaps.
  - Required response: the output sequence matches the reference model in order.
  - With IQ_COUNT_EN: sample_count=1000. Preloaded at 0xFFFFFFFF, it wraps to 0 on the next write.
